// File: rtl/ddr_clock_monitor_pkg.sv
// ddr_clock_monitor_pkg: shared lock-state encoding, fault codes and synchronizer depth.
package ddr_clock_monitor_pkg;
    typedef enum logic [1:0] {
        LOST    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } lockState_t;
    typedef logic [1:0] faultCode_t;
    localparam faultCode_t FAULT_NONE    = 2'b00;
    localparam faultCode_t FAULT_SKEW    = 2'b01;
    localparam faultCode_t FAULT_TIMEOUT = 2'b10;
    localparam faultCode_t FAULT_BOTH    = 2'b11;
    localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/ddr_clock_monitor_if.sv
// ddr_clock_monitor_if: monitored clock pair in, lock/frequency/fault status out.
interface ddr_clock_monitor_if
    import ddr_clock_monitor_pkg::*;
#(
    parameter int COUNT_W = 9
);
    logic ClockP;
    logic ClockN;
    logic Clear;
    logic ClockGood;
    logic [COUNT_W-1:0] EdgeCount;
    logic CountValid;
    logic Fault;
    faultCode_t FaultCode;
    modport master (
        output ClockP, ClockN, Clear,
        input  ClockGood, EdgeCount, CountValid, Fault, FaultCode
    );
    modport slave (
        input  ClockP, ClockN, Clear,
        output ClockGood, EdgeCount, CountValid, Fault, FaultCode
    );
endinterface

// File: rtl/ddr_clock_monitor_sync_2ff.sv
// sync_2ff: 1-bit multi-flop synchronizer with synchronous reset.
module sync_2ff
    import ddr_clock_monitor_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);
    logic [SYNC_DEPTH-1:0] stages;
    always_ff @(posedge Clock)
        stages <= Reset ? '0 : {stages[SYNC_DEPTH-2:0], d};
    assign q = stages[SYNC_DEPTH-1];
endmodule

// File: rtl/ddr_clock_monitor.sv
// ddr_clock_monitor: oversamples a differential clock pair, checks complementarity,
// counts rising edges per window and qualifies the clock with a lock FSM.
module ddr_clock_monitor
    import ddr_clock_monitor_pkg::*;
#(
    parameter int WINDOW       = 256,
    parameter int COUNT_W      = 9,
    parameter int GOOD_PERIODS = 8,
    parameter int TIMEOUT      = 16,
    parameter int SKEW_MAX     = 1
) (
    input logic Clock,
    input logic Reset,
    ddr_clock_monitor_if.slave bus
);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W  = $clog2(SKEW_MAX + 2);
    localparam int GOOD_W = $clog2(GOOD_PERIODS + 1);

    logic sP, sN, sPd, rise;
    logic legsEqual, skewEvent, timeoutEvent, anyEvent, winLast;
    faultCode_t eventCode;
    logic [WIN_W-1:0] winCnt;
    logic [COUNT_W-1:0] edgeCnt, edgeNext;
    logic [IDLE_W-1:0] idleCnt;
    logic [RUN_W-1:0] runCnt;
    logic [GOOD_W-1:0] goodCnt, goodNext;
    lockState_t state;

    sync_2ff syncP (.Clock(Clock), .Reset(Reset), .d(bus.ClockP), .q(sP));
    sync_2ff syncN (.Clock(Clock), .Reset(Reset), .d(bus.ClockN), .q(sN));

    // Skew fires once when a run of equal legs reaches SKEW_MAX+1; timeout fires once per idle stretch.
    always_comb begin
        legsEqual    = sP == sN;
        skewEvent    = legsEqual && runCnt == RUN_W'(SKEW_MAX);
        timeoutEvent = !rise && idleCnt == IDLE_W'(TIMEOUT - 1);
        anyEvent     = skewEvent || timeoutEvent;
        eventCode    = (skewEvent && timeoutEvent) ? FAULT_BOTH : timeoutEvent ? FAULT_TIMEOUT : FAULT_SKEW;
        winLast      = winCnt == WIN_W'(WINDOW - 1);
        edgeNext     = (rise && !(&edgeCnt)) ? edgeCnt + COUNT_W'(1) : edgeCnt;
        goodNext     = goodCnt + GOOD_W'(1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sPd            <= 1'b0;
            rise           <= 1'b0;
            winCnt         <= '0;
            edgeCnt        <= '0;
            idleCnt        <= '0;
            runCnt         <= '0;
            bus.EdgeCount  <= '0;
            bus.CountValid <= 1'b0;
        end else begin
            sPd            <= sP;
            rise           <= sP && !sPd;
            winCnt         <= winLast ? '0 : winCnt + WIN_W'(1);
            edgeCnt        <= winLast ? '0 : edgeNext;
            bus.CountValid <= winLast;
            if (winLast)
                bus.EdgeCount <= edgeNext;
            idleCnt <= rise ? '0 : (idleCnt == IDLE_W'(TIMEOUT)) ? idleCnt : idleCnt + IDLE_W'(1);
            runCnt  <= !legsEqual ? '0 : (runCnt == RUN_W'(SKEW_MAX + 1)) ? runCnt : runCnt + RUN_W'(1);
        end
    end

    // Events take priority over a coincident rise.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= LOST;
            goodCnt       <= '0;
            bus.ClockGood <= 1'b0;
        end else if (anyEvent) begin
            state         <= LOST;
            goodCnt       <= '0;
            bus.ClockGood <= 1'b0;
        end else if (rise) begin
            case (state)
                LOST: begin
                    state   <= LOCKING;
                    goodCnt <= GOOD_W'(1);
                end
                LOCKING: begin
                    goodCnt <= goodNext;
                    if (goodNext == GOOD_W'(GOOD_PERIODS)) begin
                        state         <= LOCKED;
                        bus.ClockGood <= 1'b1;
                    end
                end
                LOCKED: ;
                default: state <= LOST;
            endcase
        end
    end

    // A new event beats a coincident Clear and reloads the code.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.Fault     <= 1'b0;
            bus.FaultCode <= FAULT_NONE;
        end else if (anyEvent) begin
            bus.Fault <= 1'b1;
            if (!bus.Fault || bus.Clear)
                bus.FaultCode <= eventCode;
        end else if (bus.Clear) begin
            bus.Fault     <= 1'b0;
            bus.FaultCode <= FAULT_NONE;
        end
    end
endmodule
